gerenciador_teclado: RTL
========================

Name: gerenciador_teclado

Overview:
Access scheduler for the keypad resource of the lock's operational datapath. It decides when teclado_en is granted, arbitrating between four conditions: normal use, configuration (setup), "Não Perturbe" (do-not-disturb) mode, and an escalating wrong-password penalty lockout. It sits between the password checker and the keypad/display front end. It exports a countdown for the display and a bip request.

Parameters:
UM_SEGUNDO, 1000, clock cycles per second (bench overrides to 10).
T_BLOQUEIO_S, 3, seconds botao_bloqueio must be held to enter Não Perturbe.
MAX_TENTATIVAS, 3, consecutive wrong passwords that trigger a penalty.
PENAL_BASE_S, 10, penalty seconds per level; PENAL_BASE_S*3 must be ≤ 255.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
sensor_contato  in  1  1 = door closed.
botao_bloqueio  in  1  do-not-disturb button, level.
botao_interno  in  1  inside unlock button, level.
setup_on  in  1  configuration mode active.
senha_ok  in  1  one-cycle pulse: correct password.
senha_erro  in  1  one-cycle pulse: wrong password.
teclado_en  out  1  keypad enabled.
nao_perturbe  out  1  Não Perturbe mode active.
bip  out  1  one-cycle buzzer request.
tempo_restante  out  8  penalty seconds remaining (0 outside penalty).

Behaviour:
- All outputs are registered.
- Reset values: state LIVRE; teclado_en=1; nao_perturbe=0; bip=0; tempo_restante=0; falhas=0; nivel=0; all counters 0.
- Reset assertion mid-operation clears everything immediately, including nivel.
- States: LIVRE, SETUP, NAO_PERTURBE, PENALIDADE.
  - teclado_en=1 in LIVRE and SETUP; 0 otherwise.
  - nao_perturbe=1 only in NAO_PERTURBE.
- Hold counter:
  - Increments each cycle while state=LIVRE, botao_bloqueio=1 and sensor_contato=1.
  - Otherwise cleared to 0.
  - When the count reaches T_BLOQUEIO_S*UM_SEGUNDO, the next state is NAO_PERTURBE and bip pulses for 1 cycle.
  - Holding the button longer has no further effect.
  - The count must be reached in a single continuous hold; release or door opening restarts it.
- NAO_PERTURBE exits to LIVRE on either:
  - rising edge of botao_interno, or
  - sensor_contato=0.
  - senha_ok/senha_erro are ignored in this state.
- LIVRE password events:
  - senha_ok: falhas←0, nivel←0.
  - senha_erro: falhas←falhas+1.
  - If senha_ok and senha_erro arrive in the same cycle, the cycle is treated as an error.
- Entering PENALIDADE:
  - Triggered when a senha_erro brings falhas to MAX_TENTATIVAS.
  - falhas←0, nivel←min(nivel+1,3), tempo_restante←PENAL_BASE_S*new nivel.
  - Seconds prescaler restarts at 0; bip pulses for 1 cycle.
  - If the penalty trigger and the hold-threshold event occur in the same cycle, the penalty wins.
- PENALIDADE:
  - Every UM_SEGUNDO cycles, tempo_restante decrements.
  - The decrement that reaches 0 returns to LIVRE in the same update (teclado_en=1 that cycle).
  - botao_interno, botao_bloqueio, setup_on and password pulses are ignored.
  - nivel persists after the penalty; only senha_ok or reset clears it.
- SETUP:
  - Entered from LIVRE when setup_on=1; returns to LIVRE when setup_on=0.
  - Hold counter and password events are inactive in SETUP; falhas is retained.
  - setup_on is ignored in other states.
- Priority in LIVRE (highest first): penalty trigger, setup_on, hold threshold.
- Latency: every state change becomes visible on outputs 1 cycle after the causing input edge or event.

Test Plan:
1. Release reset, wait 5 cycles -> teclado_en=1, nao_perturbe=0, bip=0, tempo_restante=0.
2. sensor_contato=1; hold botao_bloqueio 2*UM_SEGUNDO cycles, release -> teclado_en stays 1. Hold again 3*UM_SEGUNDO+5 cycles -> teclado_en=0, nao_perturbe=1, exactly one bip pulse. Release -> still 0. Pulse senha_erro x3 -> still NAO_PERTURBE, tempo_restante=0. Raise botao_interno -> teclado_en=1, nao_perturbe=0 within 2 cycles.
3. From LIVRE, 3 senha_erro pulses -> teclado_en=0, tempo_restante=10, bip pulse. Value drops by 1 every UM_SEGUNDO cycles. teclado_en=1 exactly 10*UM_SEGUNDO cycles after entry.
4. Escalation: repeat 3-error bursts -> tempo_restante loads 20, then 30, then 30 (saturates). Then senha_ok followed by 3 errors -> loads 10.
5. 2 errors, senha_ok, 2 errors -> no penalty, teclado_en=1. Same-cycle senha_ok+senha_erro as the 3rd event -> penalty entered.
6. Penalty active, drop rst mid-countdown -> all outputs at reset values immediately. With sensor_contato=0, hold botao_bloqueio 4*UM_SEGUNDO -> no Não Perturbe.

Source files
------------

// File: rtl/gerenciador_teclado.sv
// gerenciador_teclado
// Decides when the keypad of the lock is usable. Four modes compete for it:
// normal use (LIVRE), configuration (SETUP), do-not-disturb (NAO_PERTURBE)
// and an escalating wrong-password lockout (PENALIDADE).
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous reset, active low
//   sensor_contato  1 = door closed
//   botao_bloqueio  do-not-disturb button (level)
//   botao_interno   inside unlock button (level)
//   setup_on        configuration mode request
//   senha_ok        one-cycle pulse, correct password
//   senha_erro      one-cycle pulse, wrong password
//   teclado_en      keypad enabled (registered)
//   nao_perturbe    do-not-disturb active (registered)
//   bip             one-cycle buzzer request (registered)
//   tempo_restante  penalty seconds left, 0 outside the lockout (registered)
module gerenciador_teclado #(
    parameter int UM_SEGUNDO     = 1000,
    parameter int T_BLOQUEIO_S   = 3,
    parameter int MAX_TENTATIVAS = 3,
    parameter int PENAL_BASE_S   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_contato,
    input  logic       botao_bloqueio,
    input  logic       botao_interno,
    input  logic       setup_on,
    input  logic       senha_ok,
    input  logic       senha_erro,
    output logic       teclado_en,
    output logic       nao_perturbe,
    output logic       bip,
    output logic [7:0] tempo_restante
);

    localparam int HOLD_CICLOS = T_BLOQUEIO_S * UM_SEGUNDO;
    localparam int HOLD_W      = $clog2(HOLD_CICLOS + 1);
    localparam int PRESC_W     = $clog2(UM_SEGUNDO + 1);
    localparam int FALHAS_W    = $clog2(MAX_TENTATIVAS + 1);

    localparam logic [7:0] CARGA1 = 8'(PENAL_BASE_S);
    localparam logic [7:0] CARGA2 = 8'(PENAL_BASE_S * 2);
    localparam logic [7:0] CARGA3 = 8'(PENAL_BASE_S * 3);

    typedef enum logic [1:0] {
        LIVRE,
        SETUP,
        NAO_PERTURBE,
        PENALIDADE
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [FALHAS_W-1:0] falhas_q, falhas_d;
    logic [1:0]          nivel_q, nivel_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [7:0]          tempo_q, tempo_d;
    logic                bip_q, bip_d;
    logic                teclado_en_q;
    logic                nao_perturbe_q;
    logic                interno_q;

    logic       segurando;
    logic       gatilho;
    logic [1:0] nivel_novo;
    logic [7:0] carga;

    // Next-state logic. In LIVRE the penalty trigger beats setup_on, which
    // beats the hold threshold; a simultaneous ok+erro counts as an error.
    always_comb begin
        estado_d   = estado_q;
        falhas_d   = falhas_q;
        nivel_d    = nivel_q;
        hold_d     = '0;
        presc_d    = presc_q;
        tempo_d    = tempo_q;
        bip_d      = 1'b0;
        segurando  = botao_bloqueio && sensor_contato;
        gatilho    = senha_erro && (falhas_q == FALHAS_W'(MAX_TENTATIVAS - 1));
        nivel_novo = (nivel_q == 2'd3) ? 2'd3 : nivel_q + 2'd1;
        case (nivel_novo)
            2'd1:    carga = CARGA1;
            2'd2:    carga = CARGA2;
            default: carga = CARGA3;
        endcase

        case (estado_q)
            LIVRE: begin
                if (senha_erro) begin
                    falhas_d = falhas_q + FALHAS_W'(1);
                end else if (senha_ok) begin
                    falhas_d = '0;
                    nivel_d  = 2'd0;
                end
                if (segurando) begin
                    hold_d = hold_q + HOLD_W'(1);
                end

                if (gatilho) begin
                    estado_d = PENALIDADE;
                    falhas_d = '0;
                    nivel_d  = nivel_novo;
                    tempo_d  = carga;
                    presc_d  = '0;
                    bip_d    = 1'b1;
                    hold_d   = '0;
                end else if (setup_on) begin
                    estado_d = SETUP;
                    hold_d   = '0;
                end else if (segurando && (hold_q == HOLD_W'(HOLD_CICLOS - 1))) begin
                    estado_d = NAO_PERTURBE;
                    bip_d    = 1'b1;
                    hold_d   = '0;
                end
            end

            SETUP: begin
                if (!setup_on) begin
                    estado_d = LIVRE;
                end
            end

            NAO_PERTURBE: begin
                // Only a fresh press of the inside button exits, not a held one.
                if ((botao_interno && !interno_q) || !sensor_contato) begin
                    estado_d = LIVRE;
                end
            end

            PENALIDADE: begin
                // The decrement that reaches zero also releases the keypad.
                if (presc_q == PRESC_W'(UM_SEGUNDO - 1)) begin
                    presc_d = '0;
                    tempo_d = tempo_q - 8'd1;
                    if (tempo_q == 8'd1) begin
                        estado_d = LIVRE;
                    end
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end

            default: begin
                estado_d = LIVRE;
            end
        endcase
    end

    // State and registered outputs; outputs are decoded from the next state
    // so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q       <= LIVRE;
            falhas_q       <= '0;
            nivel_q        <= 2'd0;
            hold_q         <= '0;
            presc_q        <= '0;
            tempo_q        <= 8'd0;
            bip_q          <= 1'b0;
            teclado_en_q   <= 1'b1;
            nao_perturbe_q <= 1'b0;
            interno_q      <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            falhas_q       <= falhas_d;
            nivel_q        <= nivel_d;
            hold_q         <= hold_d;
            presc_q        <= presc_d;
            tempo_q        <= tempo_d;
            bip_q          <= bip_d;
            teclado_en_q   <= (estado_d == LIVRE) || (estado_d == SETUP);
            nao_perturbe_q <= (estado_d == NAO_PERTURBE);
            interno_q      <= botao_interno;
        end
    end

    assign teclado_en     = teclado_en_q;
    assign nao_perturbe   = nao_perturbe_q;
    assign bip            = bip_q;
    assign tempo_restante = tempo_q;

endmodule
